// File: rtl/seq_det_pkg.sv
// Shared defaults and context record for the round-robin serial pattern detector.
package seq_det_pkg;
    localparam int NCH_DEF  = 4;
    localparam int PLEN_DEF = 4;
    localparam int PLEN_MAX = 8;
    localparam int CNTW     = 4;
    localparam int CHW      = $clog2(NCH_DEF);
    localparam logic [PLEN_MAX-1:0] PATTERN_DEF = 8'b0000_1001;

    // Sized for the largest supported pattern; narrower patterns use the low bits.
    typedef struct packed {
        logic [PLEN_MAX-1:0] shift;
        logic [CNTW-1:0]     cnt;
    } ctx_t;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c,
                                                input logic [CNTW-1:0] lim);
        return (c >= lim) ? lim : c + 1'b1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int CHW = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CHW-1:0] ptr,
    output logic [NCH-1:0] gnt,
    output logic [CHW-1:0] gnt_idx,
    output logic           any
);
    always_comb begin
        logic [CHW-1:0] idx;
        int             j;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        j       = 0;
        for (int k = 0; k < NCH; k++) begin
            j = int'(ptr) + k;
            if (j >= NCH) begin
                j = j - NCH;
            end
            idx = CHW'(j);
            if (!any && req[idx]) begin
                any     = 1'b1;
                gnt_idx = idx;
            end
        end
        gnt[gnt_idx] = any;
    end
endmodule

// File: rtl/seq_det_rr_sched.sv
// One shared pattern-detection engine time-multiplexed over NCH serial channels,
// with per-channel saved history so interleaved streams are detected independently.
module seq_det_rr_sched
    import seq_det_pkg::*;
#(
    parameter int              NCH     = NCH_DEF,
    parameter int              PLEN    = PLEN_DEF,
    parameter logic [PLEN-1:0] PATTERN = PATTERN_DEF[PLEN-1:0],
    parameter bit              OVERLAP = 1'b0,
    parameter int              CHW_L   = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   ch_valid,
    input  logic [NCH-1:0]   ch_bit,
    input  logic [NCH-1:0]   ch_clr,
    output logic [NCH-1:0]   ch_ready,
    output logic             det_valid,
    output logic [CHW_L-1:0] det_ch
);
    localparam logic [CNTW-1:0] PLEN_CNT = CNTW'(PLEN);

    ctx_t             ctx_q [NCH];
    ctx_t             ctx_d [NCH];
    logic [CHW_L-1:0] ptr_q, ptr_d;
    logic             det_valid_q, det_valid_d;
    logic [CHW_L-1:0] det_ch_q, det_ch_d;

    logic [NCH-1:0]   req, gnt;
    logic [CHW_L-1:0] gnt_idx;
    logic             any;
    ctx_t             cur_ctx, upd_ctx;
    logic [PLEN-1:0]  nshift;
    logic [CNTW-1:0]  ncnt;
    logic             hit;

    // A channel being cleared this cycle must not consume its bit.
    assign req = ch_valid & ~ch_clr;

    rr_arbiter #(.NCH(NCH), .CHW(CHW_L)) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign ch_ready = rst ? '0 : gnt;

    always_comb begin
        cur_ctx       = ctx_q[gnt_idx];
        nshift        = {cur_ctx.shift[PLEN-2:0], ch_bit[gnt_idx]};
        ncnt          = sat_inc(cur_ctx.cnt, PLEN_CNT);
        hit           = any && (nshift == PATTERN) && (ncnt == PLEN_CNT);
        upd_ctx       = '0;
        upd_ctx.shift[PLEN-1:0] = nshift;
        upd_ctx.cnt   = (hit && !OVERLAP) ? '0 : ncnt;

        ptr_d         = ptr_q;
        if (any) begin
            ptr_d = (gnt_idx == CHW_L'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
        end
        det_valid_d   = hit;
        det_ch_d      = hit ? gnt_idx : det_ch_q;
    end

    // Clear wins for its own channel; a grant to another channel proceeds in parallel.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ctx
            assign ctx_d[gi] = ch_clr[gi]                            ? '0      :
                               (any && (gnt_idx == CHW_L'(gi)))     ? upd_ctx :
                                                                      ctx_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            det_valid_q <= 1'b0;
            det_ch_q    <= '0;
            for (int i = 0; i < NCH; i++) begin
                ctx_q[i] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            det_valid_q <= det_valid_d;
            det_ch_q    <= det_ch_d;
            ctx_q       <= ctx_d;
        end
    end

    assign det_valid = det_valid_q;
    assign det_ch    = det_ch_q;
endmodule

// File: tb/tb_seq_det_rr_sched.sv
// Self-checking bench: scenario tasks plus random traffic against a queue-based model.
module tb_seq_det_rr_sched;
    localparam int NCH  = 4;
    localparam int PLEN = 4;
    localparam int CHW  = 2;
    localparam logic [PLEN-1:0] PAT = 4'b1001;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] ch_valid, ch_bit, ch_clr;
    logic [NCH-1:0] ch_ready, ch_ready_ov;
    logic           det_valid, det_valid_ov;
    logic [CHW-1:0] det_ch, det_ch_ov;

    int checks = 0;
    int errors = 0;

    int ptr_m;
    bit hist_no [NCH][$];
    bit hist_ov [NCH][$];
    bit exp_det_no, exp_det_ov;
    int exp_ch_no, exp_ch_ov;
    int grant_cnt [NCH];
    int last_g;
    int obs_det, obs_det_ov, last_obs_ch;

    always #5 clk = ~clk;

    seq_det_rr_sched #(.NCH(NCH), .PLEN(PLEN), .PATTERN(PAT), .OVERLAP(1'b0)) u_dut (
        .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_bit(ch_bit), .ch_clr(ch_clr),
        .ch_ready(ch_ready), .det_valid(det_valid), .det_ch(det_ch)
    );

    seq_det_rr_sched #(.NCH(NCH), .PLEN(PLEN), .PATTERN(PAT), .OVERLAP(1'b1)) u_dut_ov (
        .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_bit(ch_bit), .ch_clr(ch_clr),
        .ch_ready(ch_ready_ov), .det_valid(det_valid_ov), .det_ch(det_ch_ov)
    );

    // Pattern seen when the last PLEN bits since the last restart spell PAT.
    function automatic bit tail_match(input bit q[$]);
        if (q.size() < PLEN) return 1'b0;
        for (int k = 0; k < PLEN; k++) begin
            if (q[q.size() - PLEN + k] != PAT[PLEN-1-k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic step(input logic r, input logic [NCH-1:0] v,
                        input logic [NCH-1:0] b, input logic [NCH-1:0] c);
        int g;
        logic [NCH-1:0] exp_ready;
        bit h_no, h_ov;
        rst = r; ch_valid = v; ch_bit = b; ch_clr = c;
        #1;
        g = -1;
        if (!r) begin
            for (int k = 0; k < NCH; k++) begin
                int j;
                j = (ptr_m + k) % NCH;
                if (g < 0 && v[j] && !c[j]) g = j;
            end
        end
        exp_ready = (g >= 0) ? (NCH'(1) << g) : '0;
        checks++;
        if (ch_ready !== exp_ready) begin
            errors++;
            $display("FAIL ch_ready got %b exp %b", ch_ready, exp_ready);
        end
        checks++;
        if (ch_ready_ov !== exp_ready) begin
            errors++;
            $display("FAIL ch_ready_ov got %b exp %b", ch_ready_ov, exp_ready);
        end
        @(posedge clk);
        h_no = 1'b0;
        h_ov = 1'b0;
        if (r) begin
            ptr_m = 0;
            for (int i = 0; i < NCH; i++) begin
                hist_no[i].delete();
                hist_ov[i].delete();
            end
            exp_det_no = 1'b0; exp_det_ov = 1'b0;
            exp_ch_no  = 0;    exp_ch_ov  = 0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (c[i]) begin
                    hist_no[i].delete();
                    hist_ov[i].delete();
                end
            end
            if (g >= 0) begin
                hist_no[g].push_back(b[g]);
                hist_ov[g].push_back(b[g]);
                if (hist_no[g].size() > PLEN) void'(hist_no[g].pop_front());
                if (hist_ov[g].size() > PLEN) void'(hist_ov[g].pop_front());
                h_no = tail_match(hist_no[g]);
                h_ov = tail_match(hist_ov[g]);
                if (h_no) hist_no[g].delete();
                ptr_m = (g + 1) % NCH;
                grant_cnt[g]++;
            end
            exp_det_no = h_no;
            exp_det_ov = h_ov;
            if (h_no) exp_ch_no = g;
            if (h_ov) exp_ch_ov = g;
        end
        last_g = g;
        #1;
        checks++;
        if (det_valid !== exp_det_no || det_ch !== CHW'(exp_ch_no)) begin
            errors++;
            $display("FAIL det got v=%b ch=%0d exp v=%b ch=%0d", det_valid, det_ch, exp_det_no, exp_ch_no);
        end
        checks++;
        if (det_valid_ov !== exp_det_ov || det_ch_ov !== CHW'(exp_ch_ov)) begin
            errors++;
            $display("FAIL det_ov got v=%b ch=%0d exp v=%b ch=%0d", det_valid_ov, det_ch_ov, exp_det_ov, exp_ch_ov);
        end
        if (det_valid === 1'b1) begin
            obs_det++;
            last_obs_ch = int'(det_ch);
        end
        if (det_valid_ov === 1'b1) obs_det_ov++;
        $display("cyc rst=%b v=%b b=%b clr=%b rdy=%b det=%b ch=%0d det_ov=%b", r, v, b, c, ch_ready, det_valid, det_ch, det_valid_ov);
    endtask

    task automatic do_reset();
        step(1'b1, '0, '0, '0);
        step(1'b1, '0, '0, '0);
        obs_det = 0; obs_det_ov = 0; last_obs_ch = -1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (det_valid !== 1'b0 || det_ch !== '0 || ch_ready !== '0) begin
            errors++;
            $display("FAIL reset_state got v=%b ch=%0d rdy=%b exp 0/0/0", det_valid, det_ch, ch_ready);
        end
    endtask

    task automatic test_basic();
        logic [3:0] s;
        s = 4'b1001;
        do_reset();
        for (int i = 3; i >= 0; i--) step(1'b0, 4'b0001, {3'b000, s[i]}, '0);
        checks++;
        if (det_valid !== 1'b1 || det_ch !== 2'd0) begin
            errors++;
            $display("FAIL basic_latency got v=%b ch=%0d exp v=1 ch=0", det_valid, det_ch);
        end
        step(1'b0, '0, '0, '0);
        checks++;
        if (obs_det != 1) begin
            errors++;
            $display("FAIL basic_count got %0d exp 1", obs_det);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] s;
        s = 7'b1001001;
        do_reset();
        for (int i = 6; i >= 0; i--) step(1'b0, 4'b0001, {3'b000, s[i]}, '0);
        step(1'b0, '0, '0, '0);
        checks++;
        if (obs_det != 1) begin
            errors++;
            $display("FAIL nonoverlap_count got %0d exp 1", obs_det);
        end
        checks++;
        if (obs_det_ov != 2) begin
            errors++;
            $display("FAIL overlap_count got %0d exp 2", obs_det_ov);
        end
    endtask

    task automatic test_interleave();
        logic [3:0] s;
        int idx0;
        s = 4'b1001;
        idx0 = 3;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'b0011, {3'b000, (idx0 >= 0) ? s[idx0 < 0 ? 0 : idx0] : 1'b0}, '0);
            checks++;
            if (last_g != (i % 2)) begin
                errors++;
                $display("FAIL alternate got %0d exp %0d", last_g, i % 2);
            end
            if (last_g == 0) idx0--;
        end
        step(1'b0, '0, '0, '0);
        checks++;
        if (obs_det != 1 || last_obs_ch != 0) begin
            errors++;
            $display("FAIL interleave got n=%0d ch=%0d exp n=1 ch=0", obs_det, last_obs_ch);
        end
    endtask

    task automatic test_all_valid();
        int prev_g;
        bit saw_wrap;
        for (int i = 0; i < NCH; i++) grant_cnt[i] = 0;
        prev_g = -1;
        saw_wrap = 1'b0;
        for (int i = 0; i < 4 * NCH; i++) begin
            step(1'b0, '1, NCH'($urandom), '0);
            if (prev_g == NCH - 1) begin
                saw_wrap = 1'b1;
                checks++;
                if (last_g != 0) begin
                    errors++;
                    $display("FAIL ptr_wrap got %0d exp 0", last_g);
                end
            end
            prev_g = last_g;
        end
        for (int i = 0; i < NCH; i++) begin
            checks++;
            if (grant_cnt[i] != 4) begin
                errors++;
                $display("FAIL fairness ch%0d got %0d exp 4", i, grant_cnt[i]);
            end
        end
        checks++;
        if (!saw_wrap) begin
            errors++;
            $display("FAIL wrap_seen got 0 exp 1");
        end
    endtask

    task automatic test_clear();
        logic [3:0] s;
        s = 4'b1001;
        do_reset();
        step(1'b0, 4'b0100, 4'b0100, '0);
        step(1'b0, 4'b0100, 4'b0000, '0);
        step(1'b0, 4'b0100, 4'b0000, '0);
        step(1'b0, 4'b0110, 4'b0100, 4'b0100);
        checks++;
        if (last_g != 1) begin
            errors++;
            $display("FAIL clr_grant_other got %0d exp 1", last_g);
        end
        step(1'b0, 4'b0100, 4'b0100, '0);
        checks++;
        if (obs_det != 0) begin
            errors++;
            $display("FAIL clr_nodet got %0d exp 0", obs_det);
        end
        for (int i = 3; i >= 0; i--) step(1'b0, 4'b0100, {1'b0, s[i], 2'b00}, '0);
        checks++;
        if (obs_det != 1 || last_obs_ch != 2) begin
            errors++;
            $display("FAIL clr_redet got n=%0d ch=%0d exp n=1 ch=2", obs_det, last_obs_ch);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b0, 4'b0001, 4'b0001, '0);
        step(1'b0, 4'b0001, 4'b0000, '0);
        step(1'b0, 4'b0001, 4'b0000, '0);
        step(1'b1, 4'b0001, 4'b0001, '0);
        checks++;
        if (det_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_drop got %b exp 0", det_valid);
        end
        step(1'b0, '1, 4'b0001, '0);
        checks++;
        if (last_g != 0 || det_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_ctx_ptr got g=%0d v=%b exp g=0 v=0", last_g, det_valid);
        end
    endtask

    task automatic test_random();
        logic [NCH-1:0] v, b, c;
        logic r;
        for (int i = 0; i < 400; i++) begin
            v = NCH'($urandom);
            b = NCH'($urandom);
            c = NCH'($urandom) & NCH'($urandom) & NCH'($urandom);
            r = ($urandom_range(0, 99) == 0);
            step(r, v, b, c);
        end
    endtask

    initial begin
        ptr_m = 0;
        last_g = -1;
        test_reset();
        test_basic();
        test_overlap();
        test_interleave();
        test_all_valid();
        test_clear();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
